// File: rtl/aquarium_monitor_ctrl.sv
// Aquarium monitor: sensor register file with saturating updates, range-error flags,
// and an IDLE/SCAN/ERROR display sequencer driving a registered one-hot mode select.
module aquarium_monitor_ctrl #(
   parameter int unsigned DWELL       = 8,
   parameter int unsigned TEMP_MIN    = 22,
   parameter int unsigned TEMP_MAX    = 28,
   parameter int unsigned SALT_MAX    = 40,
   parameter int unsigned CLEAN_MIN   = 50,
   parameter int unsigned FOOD_MIN    = 10,
   parameter int unsigned FEED_AMOUNT = 5
) (
   input  logic       CLK,
   input  logic       reset,
   // Sample handshake: a sample transfers on a rising edge where smp_valid && smp_ready.
   // smp_ready drops whenever feed is high, so a held sample simply waits.
   input  logic       smp_valid,
   output logic       smp_ready,
   input  logic [2:0] smp_chan,
   input  logic [7:0] smp_data,
   input  logic       feed,
   input  logic       err_ack,
   output logic [7:0] fish_count,
   output logic [7:0] cleanliness,
   output logic [7:0] temperature,
   output logic [7:0] food_storage,
   output logic [7:0] saltiness,
   output logic [4:0] mode_sel,
   output logic [3:0] err_flags,
   output logic       update,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, ERROR = 2'd2} state_t;

   localparam logic [7:0] TMIN   = 8'(TEMP_MIN);
   localparam logic [7:0] TMAX   = 8'(TEMP_MAX);
   localparam logic [7:0] SMAX   = 8'(SALT_MAX);
   localparam logic [7:0] CMIN   = 8'(CLEAN_MIN);
   localparam logic [7:0] FMIN   = 8'(FOOD_MIN);
   localparam logic [7:0] FEED   = 8'(FEED_AMOUNT);
   localparam logic [7:0] DW_END = 8'(DWELL - 1);

   logic [7:0] fish_q, fish_d, clean_q, clean_d, temp_q, temp_d;
   logic [7:0] food_q, food_d, salt_q, salt_d;
   logic [3:0] seen_q, seen_d, err_q, err_d;
   logic       update_q, update_d;
   state_t     state_q, state_d;
   logic [4:0] mode_q, mode_d;
   logic [7:0] dwell_q, dwell_d;
   logic [8:0] fish_sum;
   logic       accept;

   assign smp_ready = ~feed;
   assign accept    = smp_valid & ~feed;
   assign fish_sum  = {1'b0, fish_q} + {1'b0, smp_data};

   // Seen bits share the err_flags bit order: temp, salt, clean, food.
   always_comb begin
      fish_d   = fish_q;
      clean_d  = clean_q;
      temp_d   = temp_q;
      food_d   = food_q;
      salt_d   = salt_q;
      seen_d   = seen_q;
      update_d = 1'b0;
      if (accept) begin
         case (smp_chan)
            3'd0: begin fish_d = fish_sum[8] ? 8'hFF : fish_sum[7:0]; update_d = 1'b1; end
            3'd1: begin fish_d = (fish_q >= smp_data) ? fish_q - smp_data : 8'd0; update_d = 1'b1; end
            3'd2: begin clean_d = smp_data; seen_d[2] = 1'b1; update_d = 1'b1; end
            3'd3: begin temp_d  = smp_data; seen_d[0] = 1'b1; update_d = 1'b1; end
            3'd4: begin food_d  = smp_data; seen_d[3] = 1'b1; update_d = 1'b1; end
            3'd5: begin salt_d  = smp_data; seen_d[1] = 1'b1; update_d = 1'b1; end
            default: ;
         endcase
      end
      if (feed) begin
         food_d   = (food_q >= FEED) ? food_q - FEED : 8'd0;
         update_d = 1'b1;
      end
      err_d[0] = seen_q[0] & ((temp_q < TMIN) | (temp_q > TMAX));
      err_d[1] = seen_q[1] & (salt_q > SMAX);
      err_d[2] = seen_q[2] & (clean_q < CMIN);
      err_d[3] = seen_q[3] & (food_q < FMIN);
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dwell_d = dwell_q;
      case (state_q)
         IDLE: begin
            mode_d  = 5'b00000;
            dwell_d = 8'd0;
            if (|err_q) begin
               state_d = ERROR;
               mode_d  = 5'b11111;
            end else if (accept | feed) begin
               state_d = SCAN;
               mode_d  = 5'b00001;
            end
         end
         SCAN: begin
            if (|err_q) begin
               state_d = ERROR;
               mode_d  = 5'b11111;
               dwell_d = 8'd0;
            end else if (dwell_q == DW_END) begin
               dwell_d = 8'd0;
               mode_d  = {mode_q[3:0], mode_q[4]};
            end else begin
               dwell_d = dwell_q + 8'd1;
            end
         end
         ERROR: begin
            mode_d  = 5'b11111;
            dwell_d = 8'd0;
            if (err_ack && (err_q == 4'd0)) begin
               state_d = SCAN;
               mode_d  = 5'b00001;
            end
         end
         default: begin
            state_d = IDLE;
            mode_d  = 5'b00000;
            dwell_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         fish_q   <= 8'd0;
         clean_q  <= 8'd0;
         temp_q   <= 8'd0;
         food_q   <= 8'd0;
         salt_q   <= 8'd0;
         seen_q   <= 4'd0;
         err_q    <= 4'd0;
         update_q <= 1'b0;
         state_q  <= IDLE;
         mode_q   <= 5'b00000;
         dwell_q  <= 8'd0;
      end else begin
         fish_q   <= fish_d;
         clean_q  <= clean_d;
         temp_q   <= temp_d;
         food_q   <= food_d;
         salt_q   <= salt_d;
         seen_q   <= seen_d;
         err_q    <= err_d;
         update_q <= update_d;
         state_q  <= state_d;
         mode_q   <= mode_d;
         dwell_q  <= dwell_d;
      end
   end

   assign fish_count   = fish_q;
   assign cleanliness  = clean_q;
   assign temperature  = temp_q;
   assign food_storage = food_q;
   assign saltiness    = salt_q;
   assign err_flags    = err_q;
   assign update       = update_q;
   assign mode_sel     = mode_q;
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_aquarium_monitor_ctrl.sv
// Directed bench for aquarium_monitor_ctrl: inputs change 1 ns after a rising edge,
// outputs are checked there too, against hand-computed values.
module tb_aquarium_monitor_ctrl;

   logic       CLK = 1'b0;
   logic       reset;
   logic       smp_valid, smp_ready, feed, err_ack, update;
   logic [2:0] smp_chan;
   logic [7:0] smp_data;
   logic [7:0] fish_count, cleanliness, temperature, food_storage, saltiness;
   logic [4:0] mode_sel;
   logic [3:0] err_flags;
   logic [1:0] fsm_state;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_ERROR = 2'd2;

   aquarium_monitor_ctrl dut (
      .CLK(CLK), .reset(reset),
      .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_chan(smp_chan), .smp_data(smp_data),
      .feed(feed), .err_ack(err_ack),
      .fish_count(fish_count), .cleanliness(cleanliness), .temperature(temperature),
      .food_storage(food_storage), .saltiness(saltiness),
      .mode_sel(mode_sel), .err_flags(err_flags), .update(update), .fsm_state(fsm_state)
   );

   // clock
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [2:0] chan, input logic [7:0] data);
      smp_valid = 1'b1;
      smp_chan  = chan;
      smp_data  = data;
      tick();
      smp_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; smp_valid = 1'b0; smp_chan = 3'd0; smp_data = 8'd0;
      feed = 1'b0; err_ack = 1'b0;
      #3 reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      check_val("rst_mode", 32'(mode_sel), 32'd0);
      check_val("rst_state", 32'(fsm_state), 32'(S_IDLE));
      check_val("rst_update", 32'(update), 32'd0);
      check_val("rst_flags", 32'(err_flags), 32'd0);

      // temperature write starts the scan
      send(3'd3, 8'd25);
      check_val("t1_temp", 32'(temperature), 32'd25);
      check_val("t1_update", 32'(update), 32'd1);
      check_val("t1_state", 32'(fsm_state), 32'(S_SCAN));
      check_val("t1_mode0", 32'(mode_sel), 32'd1);
      tick();
      check_val("t1_update_drop", 32'(update), 32'd0);
      check_val("t1_flags", 32'(err_flags), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_val("t1_mode_hold", 32'(mode_sel), 32'd1);
      end
      tick();
      check_val("t1_mode_next", 32'(mode_sel), 32'd2);

      // fish saturation both ways
      send(3'd0, 8'd250);
      check_val("fish_250", 32'(fish_count), 32'd250);
      send(3'd0, 8'd10);
      check_val("fish_sat_hi", 32'(fish_count), 32'd255);
      send(3'd1, 8'd255);
      check_val("fish_sat_lo", 32'(fish_count), 32'd0);

      // feed blocks a pending sample
      feed = 1'b1; smp_valid = 1'b1; smp_chan = 3'd2; smp_data = 8'd77;
      #1 check_val("stall_ready", 32'(smp_ready), 32'd0);
      tick();
      check_val("stall_clean", 32'(cleanliness), 32'd0);
      feed = 1'b0;
      #1 check_val("stall_ready_back", 32'(smp_ready), 32'd1);
      tick();
      smp_valid = 1'b0;
      check_val("stall_accept", 32'(cleanliness), 32'd77);

      // food low error and feed saturation
      send(3'd4, 8'd7);
      check_val("food_7", 32'(food_storage), 32'd7);
      check_val("food_flag_lag", 32'(err_flags), 32'd0);
      tick();
      check_val("food_flag", 32'(err_flags), 32'd8);
      tick();
      check_val("food_err_mode", 32'(mode_sel), 32'd31);
      check_val("food_err_state", 32'(fsm_state), 32'(S_ERROR));
      feed = 1'b1;
      tick();
      check_val("feed_1", 32'(food_storage), 32'd2);
      tick();
      feed = 1'b0;
      check_val("feed_2", 32'(food_storage), 32'd0);
      check_val("feed_update", 32'(update), 32'd1);

      // error exit needs ack with clear flags
      send(3'd4, 8'd100);
      send(3'd3, 8'd30);
      tick();
      check_val("hot_flag", 32'(err_flags), 32'd1);
      err_ack = 1'b1;
      tick();
      err_ack = 1'b0;
      check_val("ack_ignored", 32'(mode_sel), 32'd31);
      send(3'd3, 8'd24);
      tick();
      check_val("cool_flag", 32'(err_flags), 32'd0);
      err_ack = 1'b1;
      tick();
      err_ack = 1'b0;
      check_val("ack_exit_mode", 32'(mode_sel), 32'd1);
      check_val("ack_exit_state", 32'(fsm_state), 32'(S_SCAN));

      // async reset mid-dwell at 01000
      for (int i = 0; i < 27; i++) tick();
      check_val("pre_rst_mode", 32'(mode_sel), 32'd8);
      #2 reset = 1'b0;
      #1;
      check_val("arst_mode", 32'(mode_sel), 32'd0);
      check_val("arst_temp", 32'(temperature), 32'd0);
      check_val("arst_food", 32'(food_storage), 32'd0);
      check_val("arst_clean", 32'(cleanliness), 32'd0);
      check_val("arst_state", 32'(fsm_state), 32'(S_IDLE));
      #1 reset = 1'b1;
      tick();
      check_val("post_rst_state", 32'(fsm_state), 32'(S_IDLE));
      check_val("post_rst_flags", 32'(err_flags), 32'd0);

      // reserved channel: consumed, no write, no update
      send(3'd6, 8'd99);
      check_val("rsv_update", 32'(update), 32'd0);
      check_val("rsv_mode", 32'(mode_sel), 32'd1);
      check_val("rsv_fish", 32'(fish_count), 32'd0);

      // salinity high
      send(3'd5, 8'd41);
      check_val("salt_41", 32'(saltiness), 32'd41);
      tick();
      check_val("salt_flag", 32'(err_flags), 32'd2);
      tick();
      check_val("salt_err_mode", 32'(mode_sel), 32'd31);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
